// File: rtl/periph_bus_arbiter_if.sv
// Requester handshake and peripheral address/control signals shared by the
// arbiter (slave side) and the two requesters (master side).
interface periph_bus_arbiter_if;
   logic       REQ0;
   logic       WE0;
   logic [7:0] ADDR0;
   logic [7:0] WDATA0;
   logic       ACK0;
   logic [7:0] RDATA0;

   logic       REQ1;
   logic       WE1;
   logic [7:0] ADDR1;
   logic [7:0] WDATA1;
   logic       ACK1;
   logic [7:0] RDATA1;

   logic [7:0] BUS_ADDR;
   logic       BUS_WE;
   logic [1:0] GNT;
   logic       BUSY;

   // Requester side: issues requests, observes completion and bus status.
   modport master (
      output REQ0, WE0, ADDR0, WDATA0,
      output REQ1, WE1, ADDR1, WDATA1,
      input  ACK0, RDATA0, ACK1, RDATA1,
      input  BUS_ADDR, BUS_WE, GNT, BUSY
   );

   // Arbiter side: consumes requests, drives completion and bus control.
   modport slave (
      input  REQ0, WE0, ADDR0, WDATA0,
      input  REQ1, WE1, ADDR1, WDATA1,
      output ACK0, RDATA0, ACK1, RDATA1,
      output BUS_ADDR, BUS_WE, GNT, BUSY
   );
endinterface

// File: rtl/periph_bus_arbiter.sv
// Two-requester round-robin arbiter for the 8-bit memory-mapped peripheral
// bus. Writes take WR+IDLE; reads take RD_ADDR, RD_DATA, TURN, IDLE so the
// peripheral has released BUS_DATA before the arbiter can drive it again.
module periph_bus_arbiter #(
   parameter logic [7:0] IDLE_ADDR = 8'hFF
) (
   input  logic                 CLK,
   input  logic                 RESET,
   periph_bus_arbiter_if.slave  bus,
   inout  wire  [7:0]           BUS_DATA
);

   localparam int unsigned DW = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR,
      S_RD_ADDR,
      S_RD_DATA,
      S_TURN
   } state_t;

   state_t          r_state;
   logic            r_owner;
   logic            r_last;
   logic [1:0]      r_ack;
   logic [1:0]      r_gnt;
   logic [DW-1:0]   r_rdata0;
   logic [DW-1:0]   r_rdata1;
   logic [DW-1:0]   r_bus_addr;
   logic [DW-1:0]   r_bus_dout;
   logic            r_bus_we;
   logic            r_bus_drv;

   logic [1:0]      w_eff;
   logic            w_pick;
   logic            w_pick_we;
   logic [DW-1:0]   w_pick_addr;
   logic [DW-1:0]   w_pick_wdata;

   // A requester's REQ is masked in the cycle its own ACK is high.
   assign w_eff        = {bus.REQ1 & ~r_ack[1], bus.REQ0 & ~r_ack[0]};
   // On a tie the requester not granted last wins.
   assign w_pick       = (w_eff == 2'b11) ? ~r_last : w_eff[1];
   assign w_pick_we    = w_pick ? bus.WE1    : bus.WE0;
   assign w_pick_addr  = w_pick ? bus.ADDR1  : bus.ADDR0;
   assign w_pick_wdata = w_pick ? bus.WDATA1 : bus.WDATA0;

   // Transfer sequencer: state, grant, bus control and read capture.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state    <= S_IDLE;
         r_owner    <= 1'b0;
         r_last     <= 1'b1;
         r_ack      <= 2'b00;
         r_gnt      <= 2'b00;
         r_rdata0   <= '0;
         r_rdata1   <= '0;
         r_bus_addr <= IDLE_ADDR;
         r_bus_dout <= '0;
         r_bus_we   <= 1'b0;
         r_bus_drv  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_ack <= 2'b00;
               if (w_eff != 2'b00) begin
                  r_owner    <= w_pick;
                  r_last     <= w_pick;
                  r_gnt      <= w_pick ? 2'b10 : 2'b01;
                  r_bus_addr <= w_pick_addr;
                  r_bus_dout <= w_pick_wdata;
                  r_bus_we   <= w_pick_we;
                  r_bus_drv  <= w_pick_we;
                  r_state    <= w_pick_we ? S_WR : S_RD_ADDR;
               end else begin
                  r_gnt <= 2'b00;
               end
            end
            S_WR: begin
               r_bus_addr <= IDLE_ADDR;
               r_bus_we   <= 1'b0;
               r_bus_drv  <= 1'b0;
               r_ack      <= r_owner ? 2'b10 : 2'b01;
               r_state    <= S_IDLE;
            end
            S_RD_ADDR: begin
               r_state <= S_RD_DATA;
            end
            S_RD_DATA: begin
               if (r_owner) begin
                  r_rdata1 <= BUS_DATA;
               end else begin
                  r_rdata0 <= BUS_DATA;
               end
               r_bus_addr <= IDLE_ADDR;
               r_ack      <= r_owner ? 2'b10 : 2'b01;
               r_state    <= S_TURN;
            end
            S_TURN: begin
               r_ack   <= 2'b00;
               r_gnt   <= 2'b00;
               r_state <= S_IDLE;
            end
            default: begin
               r_bus_addr <= IDLE_ADDR;
               r_bus_we   <= 1'b0;
               r_bus_drv  <= 1'b0;
               r_ack      <= 2'b00;
               r_gnt      <= 2'b00;
               r_state    <= S_IDLE;
            end
         endcase
      end
   end

   // Tristate data: only the WR state drives the shared bus.
   assign BUS_DATA = r_bus_drv ? r_bus_dout : {DW{1'bz}};

   assign bus.ACK0     = r_ack[0];
   assign bus.ACK1     = r_ack[1];
   assign bus.RDATA0   = r_rdata0;
   assign bus.RDATA1   = r_rdata1;
   assign bus.BUS_ADDR = r_bus_addr;
   assign bus.BUS_WE   = r_bus_we;
   assign bus.GNT      = r_gnt;
   assign bus.BUSY     = (r_state != S_IDLE);

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Bench for periph_bus_arbiter: peripheral register model at C0/C1, a
// completion scoreboard, a bus-protocol monitor, a table of single
// transfers and hand-written tie, turnaround and reset sequences.
module tb_periph_bus_arbiter;

   localparam logic [7:0] A_C0   = 8'hC0;
   localparam logic [7:0] A_C1   = 8'hC1;
   localparam logic [7:0] IDLE_A = 8'hFF;

   logic       CLK = 1'b0;
   logic       RESET;
   wire  [7:0] BUS_DATA;

   periph_bus_arbiter_if bus();

   periph_bus_arbiter #(.IDLE_ADDR(8'hFF)) dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .bus      (bus),
      .BUS_DATA (BUS_DATA)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Peripheral model: registers at C0 and C1, read data driven one cycle late.
   logic [7:0] preg0 = 8'h00;
   logic [7:0] preg1 = 8'h00;
   logic       p_drv = 1'b0;
   logic [7:0] p_dout = 8'h00;

   always @(posedge CLK) begin
      if (bus.BUS_WE && bus.BUS_ADDR == A_C0) preg0 <= BUS_DATA;
      if (bus.BUS_WE && bus.BUS_ADDR == A_C1) preg1 <= BUS_DATA;
      p_drv  <= !bus.BUS_WE && (bus.BUS_ADDR == A_C0 || bus.BUS_ADDR == A_C1);
      p_dout <= (bus.BUS_ADDR == A_C1) ? preg1 : preg0;
   end

   assign BUS_DATA = p_drv ? p_dout : 8'hzz;

   // Scoreboard of expected completions, in grant order.
   typedef struct {
      int         id;
      bit         we;
      logic [7:0] rdata;
      int         exp_cyc;
   } sb_t;

   sb_t sbq[$];

   logic       prev_rd      = 1'b0;
   logic       prev_we      = 1'b0;
   int         last_rdd_cyc = -100;
   int         last_wr_cyc  = -100;
   logic [7:0] last_wr_data = 8'h00;
   int         viol         = 0;

   // Monitor: protocol violations plus scoreboard pop on every ACK cycle.
   always @(negedge CLK) begin
      logic rd_now;
      sb_t  e;
      rd_now = (bus.BUS_ADDR != IDLE_A) && !bus.BUS_WE;
      if (rd_now && prev_rd) last_rdd_cyc = cyc;
      if (bus.BUS_WE) begin
         if (prev_we || p_drv || (cyc - last_rdd_cyc < 2)) viol++;
         last_wr_cyc  = cyc;
         last_wr_data = BUS_DATA;
      end
      if (bus.ACK0 && bus.ACK1) viol++;
      prev_rd = rd_now;
      prev_we = bus.BUS_WE;
      if (bus.ACK0 || bus.ACK1) begin
         if (sbq.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_ack: ACK0=%0b ACK1=%0b with nothing outstanding (cycle %0d)",
                     bus.ACK0, bus.ACK1, cyc);
         end else begin
            e = sbq.pop_front();
            chk("ack_owner", bus.ACK1 ? 1 : 0, e.id);
            chk("ack_gnt", int'(bus.GNT), (e.id == 1) ? 2 : 1);
            if (e.exp_cyc >= 0) chk("ack_latency", cyc, e.exp_cyc);
            if (!e.we) chk("ack_rdata", (e.id == 1) ? int'(bus.RDATA1) : int'(bus.RDATA0), int'(e.rdata));
         end
      end
   end

   task automatic set_req(input int id, input bit req, input bit we,
                          input logic [7:0] addr, input logic [7:0] wdata);
      if (id == 0) begin
         bus.REQ0 = req; bus.WE0 = we; bus.ADDR0 = addr; bus.WDATA0 = wdata;
      end else begin
         bus.REQ1 = req; bus.WE1 = we; bus.ADDR1 = addr; bus.WDATA1 = wdata;
      end
   endtask

   task automatic push_sb(input int id, input bit we, input logic [7:0] rdata, input int exp_cyc);
      sb_t e;
      e.id = id; e.we = we; e.rdata = rdata; e.exp_cyc = exp_cyc;
      sbq.push_back(e);
   endtask

   task automatic wait_ack(input int id, output bit got);
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge CLK);
         got = (id == 0) ? bus.ACK0 : bus.ACK1;
      end
      if (!got) begin
         n_checks++;
         $display("FAIL ack_timeout: requester %0d saw no ACK within 20 cycles", id);
         sbq.delete();
      end
   endtask

   task automatic drop_req(input int id);
      @(posedge CLK); #1;
      if (id == 0) bus.REQ0 = 1'b0;
      else         bus.REQ1 = 1'b0;
   endtask

   // Isolated transfer from an idle arbiter; inputs are scrambled after grant.
   task automatic do_txn(input int id, input bit we, input logic [7:0] addr,
                         input logic [7:0] wdata, input logic [7:0] exp_rd);
      int t0;
      bit got;
      @(posedge CLK); #1;
      t0 = cyc;
      set_req(id, 1'b1, we, addr, wdata);
      push_sb(id, we, exp_rd, t0 + (we ? 2 : 3));
      @(posedge CLK); #1;
      set_req(id, 1'b1, ~we, ~addr, ~wdata);
      wait_ack(id, got);
      drop_req(id);
      if (we) begin
         chk("wr_cycle", last_wr_cyc, t0 + 1);
         chk("wr_data", int'(last_wr_data), int'(wdata));
      end
   endtask

   typedef struct {
      int         id;
      bit         we;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp_rdata;
      logic [7:0] exp_reg;
   } vec_t;

   vec_t       vecs[9];
   logic [7:0] exp_rd0;
   logic [7:0] exp_rd1;

   initial begin
      int  t0;
      int  bad;
      int  cnt0;
      int  cnt1;
      bit  got;

      vecs[0] = '{0, 1'b1, A_C0, 8'hA5, 8'h00, 8'hA5};
      vecs[1] = '{1, 1'b0, A_C0, 8'h00, 8'hA5, 8'hA5};
      vecs[2] = '{1, 1'b1, A_C1, 8'h3C, 8'h00, 8'h3C};
      vecs[3] = '{0, 1'b0, A_C1, 8'h00, 8'h3C, 8'h3C};
      vecs[4] = '{1, 1'b0, A_C0, 8'h00, 8'hA5, 8'hA5};
      vecs[5] = '{0, 1'b1, A_C0, 8'h5A, 8'h00, 8'h5A};
      vecs[6] = '{0, 1'b0, A_C0, 8'h00, 8'h5A, 8'h5A};
      vecs[7] = '{1, 1'b1, A_C1, 8'hC3, 8'h00, 8'hC3};
      vecs[8] = '{1, 1'b0, A_C1, 8'h00, 8'hC3, 8'hC3};

      RESET = 1'b0;
      set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
      set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
      exp_rd0 = 8'h00;
      exp_rd1 = 8'h00;
      repeat (3) @(negedge CLK);

      chk("rst_bus_addr", int'(bus.BUS_ADDR), 8'hFF);
      chk("rst_bus_we",   int'(bus.BUS_WE), 0);
      chk("rst_gnt",      int'(bus.GNT), 0);
      chk("rst_busy",     int'(bus.BUSY), 0);
      chk("rst_ack",      int'({bus.ACK1, bus.ACK0}), 0);
      chk("rst_rdata0",   int'(bus.RDATA0), 0);
      chk("rst_rdata1",   int'(bus.RDATA1), 0);
      RESET = 1'b1;

      // Idle: 20 quiet cycles.
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if (bus.BUS_ADDR != IDLE_A || bus.BUS_WE || bus.BUSY || bus.ACK0 || bus.ACK1) bad++;
      end
      chk("idle_quiet", bad, 0);

      // Simultaneous writes: grant order 0,1,0,1 from the reset pointer.
      @(posedge CLK); #1;
      t0 = cyc;
      set_req(0, 1'b1, 1'b1, A_C0, 8'h11);
      set_req(1, 1'b1, 1'b1, A_C0, 8'h22);
      push_sb(0, 1'b1, 8'h00, t0 + 2);
      push_sb(1, 1'b1, 8'h00, t0 + 4);
      push_sb(0, 1'b1, 8'h00, t0 + 6);
      push_sb(1, 1'b1, 8'h00, t0 + 8);
      cnt0 = 0;
      cnt1 = 0;
      for (int i = 0; i < 16 && (bus.REQ0 || bus.REQ1); i++) begin
         @(negedge CLK);
         if (bus.ACK0) cnt0++;
         if (bus.ACK1) cnt1++;
         @(posedge CLK); #1;
         if (cnt0 >= 2) bus.REQ0 = 1'b0;
         if (cnt1 >= 2) bus.REQ1 = 1'b0;
      end
      bus.REQ0 = 1'b0;
      bus.REQ1 = 1'b0;
      chk("tie_acks0", cnt0, 2);
      chk("tie_acks1", cnt1, 2);
      chk("tie_reg", int'(preg0), 8'h22);
      chk("tie_sb_empty", sbq.size(), 0);

      // Table of isolated transfers.
      for (int v = 0; v < 9; v++) begin
         do_txn(vecs[v].id, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].exp_rdata);
         if (!vecs[v].we) begin
            if (vecs[v].id == 0) exp_rd0 = vecs[v].exp_rdata;
            else                 exp_rd1 = vecs[v].exp_rdata;
         end
         chk("vec_reg", int'((vecs[v].addr == A_C1) ? preg1 : preg0), int'(vecs[v].exp_reg));
         chk("vec_rdata0", int'(bus.RDATA0), int'(exp_rd0));
         chk("vec_rdata1", int'(bus.RDATA1), int'(exp_rd1));
      end

      // Turnaround: read by 0 immediately followed by a write of 77 by 1.
      @(posedge CLK); #1;
      t0 = cyc;
      set_req(0, 1'b1, 1'b0, A_C0, 8'h00);
      push_sb(0, 1'b0, 8'h5A, t0 + 3);
      @(posedge CLK); #1;
      set_req(1, 1'b1, 1'b1, A_C0, 8'h77);
      push_sb(1, 1'b1, 8'h00, t0 + 6);
      wait_ack(0, got);
      drop_req(0);
      wait_ack(1, got);
      drop_req(1);
      chk("turn_rdd_cycle", last_rdd_cyc, t0 + 2);
      chk("turn_gap", last_wr_cyc - last_rdd_cyc, 3);
      chk("turn_reg", int'(preg0), 8'h77);
      chk("turn_rdata0", int'(bus.RDATA0), 8'h5A);

      // Reset during RD_DATA: abandon the read with no ACK.
      @(posedge CLK); #1;
      set_req(0, 1'b1, 1'b0, A_C0, 8'h00);
      @(posedge CLK);
      @(posedge CLK); #2;
      RESET = 1'b0;
      #1;
      chk("mid_rst_bus_addr", int'(bus.BUS_ADDR), 8'hFF);
      chk("mid_rst_bus_we",   int'(bus.BUS_WE), 0);
      chk("mid_rst_gnt",      int'(bus.GNT), 0);
      chk("mid_rst_busy",     int'(bus.BUSY), 0);
      chk("mid_rst_rdata0",   int'(bus.RDATA0), 0);
      chk("mid_rst_rdata1",   int'(bus.RDATA1), 0);
      bus.REQ0 = 1'b0;
      repeat (3) @(negedge CLK);
      RESET = 1'b1;
      repeat (5) @(negedge CLK);
      chk("post_rst_rdata0", int'(bus.RDATA0), 0);
      do_txn(0, 1'b0, A_C0, 8'h00, 8'h77);
      chk("post_rst_read", int'(bus.RDATA0), 8'h77);

      repeat (4) @(negedge CLK);
      chk("bus_violations", viol, 0);
      chk("sb_empty", sbq.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog");
   end

endmodule
